// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants for the generic inter-stage pipeline
//                register: control-bundle layout, FSM state encoding and
//                per-stage payload widths.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Control bundle width and bit positions (MSB first: RegWrite .. Branch)
    localparam int PIPE_CTRL_W  = 9;
    localparam int CTL_BRANCH   = 0;
    localparam int CTL_ALUOP0   = 1;
    localparam int CTL_ALUOP1   = 2;
    localparam int CTL_ALUSRC   = 3;
    localparam int CTL_REGDST   = 4;
    localparam int CTL_MEMWRITE = 5;
    localparam int CTL_MEMREAD  = 6;
    localparam int CTL_MEMTOREG = 7;
    localparam int CTL_REGWRITE = 8;

    // Stage occupancy encoding
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_FULL  = ST_FULL,
        S_SKID  = ST_SKID
    } pipe_state_e;

    // Payload widths of the classic five-stage boundaries
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_DATA_W  = 128;
    localparam int EX_MEM_DATA_W = 80;
    localparam int MEM_WB_DATA_W = 72;
    localparam int PIPE_DATA_W   = 128;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_slot
//  Description : One storage entry of a pipeline stage: valid flag plus
//                control and payload registers. Load captures a new entry,
//                drop invalidates it while keeping the payload visible.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_drop,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Entry register: load wins over drop; drop leaves ctrl/data untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule : pipe_stage_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised inter-stage pipeline register with valid/ready
//                handshake, 2-entry skid buffer and flush (bubble insert).
//                Control bits read as zero whenever no instruction is held.
//                Optional macro PIPE_STAGE_PERF_EN adds stall_cnt/bubble_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    pipe_state_e       r_state;
    pipe_state_e       w_next_state;
    logic              r_in_ready;
    logic              w_accept;
    logic              w_issue;
    logic              w_main_load;
    logic              w_main_drop;
    logic              w_skid_load;
    logic              w_skid_drop;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data_d;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    assign w_accept = in_valid & r_in_ready & ~flush;
    assign w_issue  = w_main_valid & out_ready;

    // Main refills from the skid entry whenever one is parked there
    assign w_main_ctrl_d = w_skid_valid ? w_skid_ctrl : in_ctrl;
    assign w_main_data_d = w_skid_valid ? w_skid_data : in_data;

    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_drop  (w_main_drop),
        .i_ctrl  (w_main_ctrl_d),
        .i_data  (w_main_data_d),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_drop  (w_skid_drop),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    // State register and registered ready (ready drops only when both entries fill)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != S_SKID);
        end
    end

    // Next-state and slot load/drop decode; flush empties both entries
    always_comb begin
        w_next_state = r_state;
        w_main_load  = 1'b0;
        w_main_drop  = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_drop  = 1'b0;
        if (flush) begin
            w_next_state = S_EMPTY;
            w_main_drop  = 1'b1;
            w_skid_drop  = 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_next_state = S_FULL;
                        w_main_load  = 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_accept && w_issue) begin
                        w_main_load  = 1'b1;
                    end else if (w_accept) begin
                        w_next_state = S_SKID;
                        w_skid_load  = 1'b1;
                    end else if (w_issue) begin
                        w_next_state = S_EMPTY;
                        w_main_drop  = 1'b1;
                    end
                end
                S_SKID: begin
                    if (w_issue) begin
                        w_next_state = S_FULL;
                        w_main_load  = 1'b1;
                        w_skid_drop  = 1'b1;
                    end
                end
                default: begin
                    w_next_state = S_EMPTY;
                    w_main_drop  = 1'b1;
                    w_skid_drop  = 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
    assign out_data  = w_main_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Free-running performance counters; wrap naturally, unaffected by flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_main_valid && !out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!w_main_valid) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

`ifndef SYNTHESIS
    logic              r_chk_hold;
    logic [CTRL_W-1:0] r_chk_ctrl;
    logic [DATA_W-1:0] r_chk_data;

    // Remember a stalled upstream beat so its stability can be checked next edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chk_hold <= 1'b0;
            r_chk_ctrl <= '0;
            r_chk_data <= '0;
        end else begin
            r_chk_hold <= in_valid & ~r_in_ready & ~flush;
            r_chk_ctrl <= in_ctrl;
            r_chk_data <= in_data;
        end
    end

    // Upstream must not change a beat that is still waiting for ready
    always @(posedge clk) begin
        if (reset && r_chk_hold && in_valid) begin
            assert (in_ctrl == r_chk_ctrl && in_data == r_chk_data);
        end
    end
`endif

endmodule : pipe_stage_reg
`default_nettype wire
